// File: rtl/axi_mem_txn_limiter.sv
// Outstanding-transaction limiter for the core memory AXI4 path: gates AR/AW handshakes
// against per-direction burst limits, passes everything else through, and flags stalls/underflows.
module axi_mem_txn_limiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 1,
    parameter int MAX_RD  = 8,
    parameter int MAX_WR  = 8,
    parameter int TIMEOUT = 1 << 20
) (
    input  logic                uncoreclk,
    input  logic                uncorerst,
    // slave side (from pardcore)
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    // master side (to addr_mapper)
    output logic [ID_W-1:0]     m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_W-1:0]     m_axi_rid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    // status
    input  logic                err_clr,
    output logic                err_timeout,
    output logic                err_protocol,
    output logic [7:0]          rd_outstanding,
    output logic [7:0]          wr_outstanding
);

    localparam int IDLE_W = ($clog2(TIMEOUT) > 20) ? $clog2(TIMEOUT) : 20;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_ARM = IDLE_W'(TIMEOUT - 2);

    // index 0 = read direction, index 1 = write direction
    logic [1:0]  ok, inc, dec, uflow;
    logic [15:0] cnt_all;

    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_wvalid  = s_axi_wvalid;
    assign s_axi_wready  = m_axi_wready;
    assign s_axi_rid     = m_axi_rid;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rvalid  = m_axi_rvalid;
    assign m_axi_rready  = s_axi_rready;
    assign s_axi_bid     = m_axi_bid;
    assign s_axi_bresp   = m_axi_bresp;
    assign s_axi_bvalid  = m_axi_bvalid;
    assign m_axi_bready  = s_axi_bready;

    // ok[] comes only from registered counts, so ready never depends on valid
    assign m_axi_arvalid = s_axi_arvalid & ok[0];
    assign s_axi_arready = m_axi_arready & ok[0];
    assign m_axi_awvalid = s_axi_awvalid & ok[1];
    assign s_axi_awready = m_axi_awready & ok[1];

    assign inc[0] = m_axi_arvalid & m_axi_arready;
    assign dec[0] = m_axi_rvalid & s_axi_rready & m_axi_rlast;
    assign inc[1] = m_axi_awvalid & m_axi_awready;
    assign dec[1] = m_axi_bvalid & s_axi_bready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            localparam logic [7:0] LIMIT = (gi == 0) ? 8'(MAX_RD) : 8'(MAX_WR);
            logic [7:0] cnt_reg, cnt_next;

            assign ok[gi]    = (cnt_reg < LIMIT);
            assign uflow[gi] = dec[gi] & ~inc[gi] & (cnt_reg == 8'd0);
            assign cnt_all[gi*8 +: 8] = cnt_reg;

            always_comb begin
                cnt_next = cnt_reg;
                if (inc[gi] && !dec[gi]) begin
                    cnt_next = cnt_reg + 8'd1;
                end else if (dec[gi] && !inc[gi] && cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end

            always_ff @(posedge uncoreclk) begin
                if (uncorerst) cnt_reg <= 8'd0;
                else           cnt_reg <= cnt_next;
            end
        end
    endgenerate

    assign rd_outstanding = cnt_all[7:0];
    assign wr_outstanding = cnt_all[15:8];

    // watchdog: any response progress or an empty pipe restarts the stall count
    logic [IDLE_W-1:0] idle_reg, idle_next;
    logic idle_clr, timeout_set, protocol_set;
    logic err_timeout_reg, err_protocol_reg;

    assign idle_clr = (cnt_all == 16'd0) | (m_axi_rvalid & s_axi_rready)
                    | (m_axi_bvalid & s_axi_bready);
    assign timeout_set  = ~idle_clr & (idle_reg >= IDLE_ARM);
    assign protocol_set = |uflow;

    always_comb begin
        idle_next = idle_reg;
        if (idle_clr)               idle_next = '0;
        else if (idle_reg != IDLE_MAX) idle_next = idle_reg + 1'b1;
    end

    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            idle_reg         <= '0;
            err_timeout_reg  <= 1'b0;
            err_protocol_reg <= 1'b0;
        end else begin
            idle_reg <= idle_next;
            // a set condition outranks a simultaneous clear
            if (timeout_set)      err_timeout_reg <= 1'b1;
            else if (err_clr)     err_timeout_reg <= 1'b0;
            if (protocol_set)     err_protocol_reg <= 1'b1;
            else if (err_clr)     err_protocol_reg <= 1'b0;
        end
    end

    assign err_timeout  = err_timeout_reg;
    assign err_protocol = err_protocol_reg;

endmodule

// File: tb/tb_axi_mem_txn_limiter.sv
// Bench for axi_mem_txn_limiter: directed vector table, hand-written corner sequences,
// then randomized handshakes against a counting reference model.
module tb_axi_mem_txn_limiter;

    localparam int ADDR_W = 32, DATA_W = 64, ID_W = 1;
    localparam int MAX_RD = 8, MAX_WR = 4, TIMEOUT = 16;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [ID_W-1:0] s_arid, s_awid, m_arid, m_awid, s_rid, s_bid, m_rid, m_bid;
    logic [ADDR_W-1:0] s_araddr, s_awaddr, m_araddr, m_awaddr;
    logic [7:0] s_arlen, s_awlen, m_arlen, m_awlen;
    logic [2:0] s_arsize, s_awsize, m_arsize, m_awsize, s_arprot, s_awprot, m_arprot, m_awprot;
    logic [1:0] s_arburst, s_awburst, m_arburst, m_awburst, s_rresp, m_rresp, s_bresp, m_bresp;
    logic s_arlock, s_awlock, m_arlock, m_awlock;
    logic [3:0] s_arcache, s_awcache, m_arcache, m_awcache;
    logic s_arvalid, s_arready, m_arvalid, m_arready, s_awvalid, s_awready, m_awvalid, m_awready;
    logic [DATA_W-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [DATA_W/8-1:0] s_wstrb, m_wstrb;
    logic s_wlast, m_wlast, s_wvalid, m_wvalid, s_wready, m_wready;
    logic s_rlast, m_rlast, s_rvalid, m_rvalid, s_rready, m_rready;
    logic s_bvalid, m_bvalid, s_bready, m_bready;
    logic err_clr, err_timeout, err_protocol;
    logic [7:0] rd_out, wr_out;

    axi_mem_txn_limiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                          .MAX_RD(MAX_RD), .MAX_WR(MAX_WR), .TIMEOUT(TIMEOUT)) dut (
        .uncoreclk(clk), .uncorerst(rst),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
        .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock), .s_axi_arcache(s_arcache),
        .s_axi_arprot(s_arprot), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
        .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock), .s_axi_awcache(s_awcache),
        .s_axi_awprot(s_awprot), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
        .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
        .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
        .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache),
        .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
        .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock), .m_axi_awcache(m_awcache),
        .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .err_clr(err_clr), .err_timeout(err_timeout), .err_protocol(err_protocol),
        .rd_outstanding(rd_out), .wr_outstanding(wr_out)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        {s_arid, s_awid, m_rid, m_bid} = '0;
        {s_araddr, s_awaddr} = '0;
        {s_arlen, s_awlen, s_arsize, s_awsize, s_arprot, s_awprot} = '0;
        {s_arburst, s_awburst, m_rresp, m_bresp, s_arlock, s_awlock, s_arcache, s_awcache} = '0;
        {s_arvalid, m_arready, s_awvalid, m_awready} = '0;
        {s_wdata, m_rdata, s_wstrb, s_wlast, s_wvalid, m_wready} = '0;
        {m_rlast, m_rvalid, s_rready, m_bvalid, s_bready, err_clr} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic arv, ary, awv, awy, rv, rr, rl, bv, br, clr;
        logic exp_arrdy;
        int   exp_rd, exp_wr;
        logic exp_ep;
    } vec_t;

    vec_t vecs[13];

    // reference model state
    int mrd, mwr, midle;
    bit mep, met;

    task automatic model_step();
        bit ar_hs, aw_hs, r_end, b_hs, r_beat, clr_idle;
        bit set_ep;
        ar_hs  = s_arvalid && m_arready && (mrd < MAX_RD);
        aw_hs  = s_awvalid && m_awready && (mwr < MAX_WR);
        r_beat = m_rvalid && s_rready;
        r_end  = r_beat && m_rlast;
        b_hs   = m_bvalid && s_bready;
        clr_idle = (mrd == 0 && mwr == 0) || r_beat || b_hs;
        set_ep = (r_end && !ar_hs && mrd == 0) || (b_hs && !aw_hs && mwr == 0);
        mrd = mrd + int'(ar_hs) - ((r_end && mrd > 0) || (r_end && ar_hs) ? 1 : 0);
        mwr = mwr + int'(aw_hs) - ((b_hs && mwr > 0) || (b_hs && aw_hs) ? 1 : 0);
        midle = clr_idle ? 0 : ((midle + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : midle + 1);
        if (set_ep) mep = 1; else if (err_clr) mep = 0;
        if (!clr_idle && midle == TIMEOUT - 1) met = 1; else if (err_clr) met = 0;
    endtask

    initial begin
        idle_inputs();
        //           arv ary awv awy rv rr rl bv br clr arrdy rd wr ep
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1,  1, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0,   0,  1, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0,   0,  1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0,   0,  1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0,   0,  0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0,  0, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0};
        vecs[7]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0,   0,  0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0,   0,  0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1,   0,  0, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0,  0, 0, 0};
        vecs[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   1,  0, 1, 0};
        vecs[12] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0,   1,  1, 0, 0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", rd_out, 0);
        chk("reset_wr", wr_out, 0);
        chk("reset_ep", err_protocol, 0);
        chk("reset_et", err_timeout, 0);
        rst = 1'b0;

        // directed vector table
        foreach (vecs[i]) begin
            @(negedge clk);
            {s_arvalid, m_arready, s_awvalid, m_awready} =
                {vecs[i].arv, vecs[i].ary, vecs[i].awv, vecs[i].awy};
            {m_rvalid, s_rready, m_rlast, m_bvalid, s_bready, err_clr} =
                {vecs[i].rv, vecs[i].rr, vecs[i].rl, vecs[i].bv, vecs[i].br, vecs[i].clr};
            #1;
            chk($sformatf("vec%0d_s_arready", i), s_arready, vecs[i].exp_arrdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rd", i), rd_out, vecs[i].exp_rd);
            chk($sformatf("vec%0d_wr", i), wr_out, vecs[i].exp_wr);
            chk($sformatf("vec%0d_ep", i), err_protocol, vecs[i].exp_ep);
            chk($sformatf("vec%0d_et", i), err_timeout, 0);
            $display("vec %0d: rd=%0d wr=%0d ep=%0d", i, rd_out, wr_out, err_protocol);
        end

        // fill to MAX_RD, block the 9th, same-cycle rlast keeps it blocked, then reopen
        do_reset();
        @(negedge clk);
        s_arvalid = 1'b1; m_arready = 1'b1;
        for (int k = 0; k < MAX_RD; k++) begin
            #1 chk($sformatf("fill%0d_s_arready", k), s_arready, 1);
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk("full_rd", rd_out, MAX_RD);
        #1;
        chk("full_s_arready", s_arready, 0);
        chk("full_m_arvalid", m_arvalid, 0);
        m_rvalid = 1'b1; s_rready = 1'b1; m_rlast = 1'b1;
        #1;
        chk("full_rlast_s_arready", s_arready, 0);
        chk("full_rlast_m_arvalid", m_arvalid, 0);
        @(posedge clk); #1;
        chk("after_rlast_rd", rd_out, MAX_RD - 1);
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        chk("reopen_s_arready", s_arready, 1);
        chk("reopen_m_arvalid", m_arvalid, 1);
        @(posedge clk); #1;
        chk("reopen_rd", rd_out, MAX_RD);
        chk("limit_ep", err_protocol, 0);
        $display("read limit sequence: rd=%0d", rd_out);

        // watchdog: one write outstanding, B withheld
        do_reset();
        @(negedge clk);
        s_awvalid = 1'b1; m_awready = 1'b1;
        @(posedge clk); #1;
        chk("wd_wr", wr_out, 1);
        @(negedge clk);
        s_awvalid = 1'b0;
        repeat (TIMEOUT - 2) @(posedge clk);
        #1 chk("wd_before", err_timeout, 0);
        @(posedge clk); #1;
        chk("wd_at", err_timeout, 1);
        @(negedge clk);
        m_bvalid = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1;
        chk("wd_b_wr", wr_out, 0);
        @(negedge clk);
        m_bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("wd_sticky", err_timeout, 1);
        chk("wd_no_ep", err_protocol, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        chk("wd_clr", err_timeout, 0);
        err_clr = 1'b0;
        $display("watchdog sequence: et=%0d", err_timeout);

        // reset with reads in flight and a sticky flag set
        do_reset();
        @(negedge clk);
        m_bvalid = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_ep", err_protocol, 1);
        @(negedge clk);
        m_bvalid = 1'b0;
        s_arvalid = 1'b1; m_arready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("pre_rst_rd", rd_out, 3);
        @(negedge clk);
        s_arvalid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rd", rd_out, 0);
        chk("rst_ep", err_protocol, 0);
        chk("rst_et", err_timeout, 0);
        chk("rst_s_arready_hi", s_arready, 1);
        m_arready = 1'b0;
        #1 chk("rst_s_arready_lo", s_arready, 0);
        $display("reset-in-flight sequence: rd=%0d", rd_out);

        // randomized traffic against the reference model
        do_reset();
        mrd = 0; mwr = 0; midle = 0; mep = 0; met = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            s_arvalid = ($urandom_range(99) < 50);
            m_arready = ($urandom_range(99) < 70);
            s_awvalid = ($urandom_range(99) < 40);
            m_awready = ($urandom_range(99) < 70);
            m_rvalid  = ($urandom_range(99) < 45);
            s_rready  = ($urandom_range(99) < 75);
            m_rlast   = ($urandom_range(99) < 40);
            m_bvalid  = ($urandom_range(99) < 30);
            s_bready  = ($urandom_range(99) < 75);
            err_clr   = ($urandom_range(99) < 4);
            s_araddr  = $urandom;
            m_rdata   = {$urandom, $urandom};
            s_wvalid  = $urandom_range(1);
            #1;
            chk("rnd_s_arready", s_arready, m_arready && (mrd < MAX_RD));
            chk("rnd_m_arvalid", m_arvalid, s_arvalid && (mrd < MAX_RD));
            chk("rnd_s_awready", s_awready, m_awready && (mwr < MAX_WR));
            chk("rnd_m_awvalid", m_awvalid, s_awvalid && (mwr < MAX_WR));
            chk("rnd_araddr", m_araddr, s_araddr);
            chk("rnd_rdata", s_rdata, m_rdata);
            chk("rnd_wvalid", m_wvalid, s_wvalid);
            if (s_arvalid && m_arready && mrd < MAX_RD)
                $display("rnd %0d: AR accepted addr=%08h", cyc, s_araddr);
            if (s_awvalid && m_awready && mwr < MAX_WR)
                $display("rnd %0d: AW accepted", cyc);
            model_step();
            @(posedge clk); #1;
            chk("rnd_rd", rd_out, mrd);
            chk("rnd_wr", wr_out, mwr);
            chk("rnd_ep", err_protocol, mep);
            chk("rnd_et", err_timeout, met);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
